store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 137 +++++++++++++
 tb/tb_store_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer
//   Write-back store buffer between a CPU data port and a single-ported data
//   memory. Stores are queued in a circular FIFO and drained to memory one per
//   cycle whenever the memory port is not needed by a load miss. Loads are
//   forwarded from the youngest matching pending store; otherwise they read
//   memory directly.
//
// Ports
//   clock      : single clock, state updates on the rising edge
//   reset_n    : asynchronous active-low reset
//   cpu_addr   : CPU access address (ADDR_W)
//   cpu_read   : CPU load request
//   cpu_write  : CPU store request
//   cpu_wdata  : store data (DATA_W)
//   cpu_rdata  : load result, combinational (DATA_W)
//   stall      : store not accepted this cycle
//   mem_addr   : data memory address (ADDR_W)
//   mem_read   : data memory read enable
//   mem_write  : data memory write enable (memory commits on falling edge)
//   mem_wdata  : data memory write data (DATA_W)
//   mem_rdata  : data memory combinational read data (DATA_W)
//   count      : number of occupied entries (clog2(DEPTH)+1)
//   empty      : asserted when count == 0
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic                     cpu_read,
  input  logic                     cpu_write,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     stall,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  // Entry storage; contents are only meaningful under the occupancy count,
  // so no reset is needed here.
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   occ;

  logic [PW-1:0]     lk_idx;
  logic              hit;
  logic [DATA_W-1:0] fwd_data;
  logic              miss;
  logic              drain;
  logic              push;

  // Forwarding lookup: walk from oldest (head) to youngest so the last match
  // seen is the youngest store to this address.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    lk_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lk_idx = head + PW'(i);
      if (((PW+1)'(i) < occ) && (ent_addr[lk_idx] == cpu_addr)) begin
        hit      = 1'b1;
        fwd_data = ent_data[lk_idx];
      end
    end
  end

  // The memory port goes to a load miss first; a drain only uses it when
  // free. Everything is gated by reset_n so no access occurs while in reset.
  always_comb begin
    miss  = reset_n & cpu_read & ~hit;
    drain = reset_n & ~miss & (occ != '0);
    stall = reset_n & cpu_write & (occ == FULL) & ~drain;
    push  = reset_n & cpu_write & ~stall;
  end

  always_comb begin
    mem_read  = miss;
    mem_write = drain;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    if (miss) begin
      mem_addr  = cpu_addr;
      cpu_rdata = mem_rdata;
    end else if (drain) begin
      mem_addr  = ent_addr[head];
      mem_wdata = ent_data[head];
    end
    if (cpu_read && hit) begin
      cpu_rdata = fwd_data;
    end
  end

  assign count = occ;
  assign empty = (occ == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (drain) begin
        head <= head + PW'(1);
      end
      case ({push, drain})
        2'b10:   occ <= occ + (PW+1)'(1);
        2'b01:   occ <= occ - (PW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      ent_addr[tail] <= cpu_addr;
      ent_data[tail] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int NWORDS = 1 << ADDR_W;

  logic              clock;
  logic              reset_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [$clog2(DEPTH):0] count;
  logic              empty;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_addr  (cpu_addr),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .count     (count),
    .empty     (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory seen by the DUT: combinational read, commit on falling edge.
  logic [DATA_W-1:0] tbmem [NWORDS];
  assign mem_rdata = tbmem[mem_addr];
  always @(negedge clock) begin
    if (mem_write) tbmem[mem_addr] <= mem_wdata;
  end

  // Reference model: pending stores in program order plus expected memory.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t              q[$];
  logic [DATA_W-1:0] refmem [NWORDS];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input logic rd, input logic wr,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic              e_hit;
    logic [DATA_W-1:0] e_fwd;
    logic              e_miss;
    logic              e_drain;
    logic              e_stall;
    logic [DATA_W-1:0] e_rdata;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    #2;
    e_hit = 1'b0;
    e_fwd = '0;
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].a == a) begin
        e_hit = 1'b1;
        e_fwd = q[k].d;
        break;
      end
    end
    e_miss  = rd && !e_hit;
    e_drain = !e_miss && (q.size() > 0);
    e_stall = wr && (q.size() == DEPTH) && !e_drain;
    e_rdata = !rd ? '0 : (e_hit ? e_fwd : refmem[a]);
    chk("count",     64'(count),     64'(q.size()));
    chk("empty",     64'(empty),     64'(q.size() == 0));
    chk("stall",     64'(stall),     64'(e_stall));
    chk("mem_read",  64'(mem_read),  64'(e_miss));
    chk("mem_write", 64'(mem_write), 64'(e_drain));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(e_rdata));
    if (e_miss)  chk("miss_addr",  64'(mem_addr),  64'(a));
    if (e_drain) begin
      chk("drain_addr", 64'(mem_addr),  64'(q[0].a));
      chk("drain_data", 64'(mem_wdata), 64'(q[0].d));
    end
    @(posedge clock);
    #1;
    if (e_drain) begin
      refmem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (wr && !e_stall) q.push_back('{a: a, d: d});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      tbmem[i]  = 32'h1000_0000 + 32'(i * 3);
      refmem[i] = 32'h1000_0000 + 32'(i * 3);
    end
    reset_n   = 1'b0;
    cpu_read  = 1'b0;
    cpu_write = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    #12;
    chk("rst_count",  64'(count),     64'd0);
    chk("rst_empty",  64'(empty),     64'd1);
    chk("rst_stall",  64'(stall),     64'd0);
    chk("rst_mwrite", 64'(mem_write), 64'd0);
    cpu_write = 1'b0;
    reset_n   = 1'b1;
    @(posedge clock);
    #1;

    // Single store drains on the following cycle.
    step(1'b0, 1'b1, 7'd11, 32'd80);
    chk("s034_count", 64'(count), 64'd1);
    chk("s034_mwrite", 64'(mem_write), 64'd1);
    chk("s034_maddr",  64'(mem_addr),  64'd11);
    chk("s034_mwdata", 64'(mem_wdata), 64'd80);
    idle(1);
    chk("s034_empty", 64'(empty), 64'd1);
    idle(1);

    // Youngest of two same-address stores is forwarded.
    step(1'b0, 1'b1, 7'd3, 32'd5);
    step(1'b1, 1'b1, 7'd3, 32'd9);
    cpu_addr = 7'd20;
    step(1'b1, 1'b0, 7'd3, 32'd0);
    idle(3);

    // Fill under continuous misses, then push into a full buffer while draining.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 7'(50 + i), 32'(100 + i));
    chk("s036_full", 64'(count), 64'd4);
    step(1'b0, 1'b1, 7'd60, 32'd200);
    chk("s036_count", 64'(count), 64'd4);
    // Full buffer, store plus miss: stalled, nothing pushed.
    step(1'b1, 1'b1, 7'd40, 32'd300);
    chk("s037_count", 64'(count), 64'd4);
    idle(DEPTH + 1);

    // Reset mid-operation discards pending stores.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 7'(70 + i), 32'(400 + i));
    cpu_write = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk("s038_count",  64'(count),     64'd0);
    chk("s038_empty",  64'(empty),     64'd1);
    chk("s038_stall",  64'(stall),     64'd0);
    chk("s038_mwrite", 64'(mem_write), 64'd0);
    #2;
    reset_n   = 1'b1;
    cpu_write = 1'b0;
    q.delete();
    @(posedge clock);
    #1;
    idle(4);

    // Eight stores, tail wraps twice; memory must follow program order.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 7'(80 + (i % 3)), 32'(500 + i));
    idle(DEPTH + 1);
    for (int i = 80; i < 83; i++) chk("s039_mem", 64'(tbmem[i]), 64'(refmem[i]));

    // Randomized traffic over a small address window to provoke hits.
    for (int n = 0; n < 400; n++) begin
      logic rd, wr;
      logic [ADDR_W-1:0] a;
      rd = ($urandom_range(0, 99) < 45);
      wr = ($urandom_range(0, 99) < 55);
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, NWORDS - 1))
                                       : 7'($urandom_range(0, 7));
      step(rd, wr, a, $urandom);
    end
    idle(DEPTH + 1);
    for (int i = 0; i < NWORDS; i++) chk("final_mem", 64'(tbmem[i]), 64'(refmem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
